// File: rtl/i2c_cmd_pkg.sv
// Shared types and helpers for the I2C command/control register.
//   state_t      : command FSM states
//   CMD_*        : bit positions of the one-hot command field
//   is_onehot()  : true when exactly one bit of the argument is set
package i2c_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_TX    = 2;
  localparam int CMD_RX    = 3;

  // v & (v-1) clears the lowest set bit; zero afterwards means a single bit was set
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Cycle counter bounding how long a command may wait for completion.
//   clk, n_rst : clock, async active-low reset
//   en         : count this cycle (saturates at TIMEOUT)
//   clr        : synchronous clear, wins over en
//   expired    : high while enabled on the cycle the count equals TIMEOUT-1
module cmd_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                cnt <= '0;
    else if (clr)                              cnt <= '0;
    else if (en && (cnt != CW'(TIMEOUT)))      cnt <= cnt + CW'(1);
  end

  // The count starts at 0 on the first waiting cycle, so this fires on cycle TIMEOUT.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/i2c_cmd_reg.sv
// Software command/control register for the APB I2C block.
// Holds level config bits, issues one-hot command strobes to the controller
// over valid/ready, tracks completion/timeout and keeps sticky error flags.
//   clk, n_rst : clock, async active-low reset
//   write_en   : APB write strobe, wdata = {cmd, cfg}
//   clear_err  : clears wr_err / tout_err (a same-cycle set wins)
//   cmd_ready  : controller accepts cmd_out
//   cmd_done   : controller pulse, command finished
//   cfg_out    : current configuration
//   cmd_out    : latched command, zero outside ISSUE / WAIT_DONE
//   cmd_valid  : high in ISSUE
//   busy       : high whenever not IDLE
//   done_pulse : one cycle in DONE
//   wr_err     : sticky, a write was rejected
//   tout_err   : sticky, a command timed out
module i2c_cmd_reg
  import i2c_cmd_pkg::*;
#(
  parameter int CFG_W   = 8,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   write_en,
  input  logic [CFG_W+CMD_W-1:0] wdata,
  input  logic                   clear_err,
  input  logic                   cmd_ready,
  input  logic                   cmd_done,
  output logic [CFG_W-1:0]       cfg_out,
  output logic [CMD_W-1:0]       cmd_out,
  output logic                   cmd_valid,
  output logic                   busy,
  output logic                   done_pulse,
  output logic                   wr_err,
  output logic                   tout_err
);

  state_t           state;
  logic [CMD_W-1:0] wcmd;
  logic [CFG_W-1:0] wcfg;
  logic             expired;
  logic             cmd_onehot;
  logic             wr_bad;
  logic             tout_hit;

  assign {wcmd, wcfg} = wdata;
  assign cmd_onehot   = is_onehot(32'(wcmd));

  // Rejected: any write while a command is in flight, or a multi-bit command.
  assign wr_bad   = write_en && ((state != IDLE) || ((wcmd != '0) && !cmd_onehot));
  // cmd_done on the expiry cycle counts as a normal completion.
  assign tout_hit = (state == WAIT_DONE) && expired && !cmd_done;

  cmd_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tcnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .en      (state == WAIT_DONE),
    .clr     (state != WAIT_DONE),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cfg_out <= '0;
      cmd_out <= '0;
    end else begin
      case (state)
        IDLE: if (write_en) begin
          if (wcmd == '0) begin
            cfg_out <= wcfg;
          end else if (cmd_onehot) begin
            cfg_out <= wcfg;
            cmd_out <= wcmd;
            state   <= ISSUE;
          end
        end
        ISSUE: if (cmd_ready) begin
          if (cmd_done) begin
            cmd_out <= '0;
            state   <= DONE;
          end else begin
            state   <= WAIT_DONE;
          end
        end
        WAIT_DONE: if (cmd_done || expired) begin
          cmd_out <= '0;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_err   <= 1'b0;
      tout_err <= 1'b0;
    end else begin
      if (wr_bad)         wr_err   <= 1'b1;
      else if (clear_err) wr_err   <= 1'b0;
      if (tout_hit)       tout_err <= 1'b1;
      else if (clear_err) tout_err <= 1'b0;
    end
  end

  assign cmd_valid  = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done_pulse = (state == DONE);

endmodule

// File: tb/tb_i2c_cmd_reg.sv
// Scoreboard bench for i2c_cmd_reg: the driver pushes the expected outcome of
// each command, an independent monitor pops and compares on cmd_valid/done_pulse.
module tb_i2c_cmd_reg;
  import i2c_cmd_pkg::*;

  localparam int CFG_W = 8;
  localparam int CMD_W = 4;
  localparam int TO    = 16;

  logic                   clk = 1'b0;
  logic                   n_rst = 1'b0;
  logic                   write_en = 1'b0;
  logic [CFG_W+CMD_W-1:0] wdata = '0;
  logic                   clear_err = 1'b0;
  logic                   cmd_ready = 1'b0;
  logic                   cmd_done = 1'b0;
  logic [CFG_W-1:0]       cfg_out;
  logic [CMD_W-1:0]       cmd_out;
  logic                   cmd_valid, busy, done_pulse, wr_err, tout_err;

  i2c_cmd_reg #(.CFG_W(CFG_W), .CMD_W(CMD_W), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .write_en(write_en), .wdata(wdata),
    .clear_err(clear_err), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .cfg_out(cfg_out), .cmd_out(cmd_out), .cmd_valid(cmd_valid), .busy(busy),
    .done_pulse(done_pulse), .wr_err(wr_err), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CFG_W-1:0] cfg;
    logic [CMD_W-1:0] cmd;
    int               valid_cyc;
    int               wait_cyc;
    bit               tout;
    bit               wr;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   exp_done = 0;
  int   popped = 0;

  // reference state of the register as software would see it
  logic [CFG_W-1:0] cfg_m = '0;
  bit               wr_m = 1'b0;
  bit               tout_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    int busy_cnt;
    int valid_cnt;
    bit prev_valid;
    exp_t e;
    busy_cnt = 0; valid_cnt = 0; prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        busy_cnt = 0; valid_cnt = 0; prev_valid = 1'b0;
      end else begin
        if (busy)      busy_cnt++;
        if (cmd_valid) valid_cnt++;
        if (cmd_valid && !prev_valid) begin
          if (q.size() == 0) check("valid_unexpected", 1, 0);
          else begin
            check("issue_cmd", cmd_out, q[0].cmd);
            check("issue_cfg", cfg_out, q[0].cfg);
          end
        end else if (busy && !done_pulse && q.size() != 0) begin
          check("hold_cmd", cmd_out, q[0].cmd);
        end
        if (done_pulse) begin
          if (q.size() == 0) check("done_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            popped++;
            check("valid_cycles", valid_cnt, e.valid_cyc);
            check("busy_cycles", busy_cnt, e.valid_cyc + e.wait_cyc + 1);
            check("done_tout_err", tout_err, e.tout);
            check("done_wr_err", wr_err, e.wr);
            check("done_cfg", cfg_out, e.cfg);
            check("done_cmd_zero", cmd_out, 0);
          end
          busy_cnt = 0; valid_cnt = 0;
        end
        prev_valid = cmd_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // IDLE write that must not start a command (zero or multi-bit cmd field)
  task automatic idle_write(input logic [CFG_W-1:0] cfg, input logic [CMD_W-1:0] cmd, input bit clr);
    bit bad;
    bad = (cmd != 0) && ($countones(cmd) > 1);
    write_en = 1'b1; wdata = {cmd, cfg}; clear_err = clr;
    if (cmd == 0) cfg_m = cfg;
    if (bad)      wr_m = 1'b1;
    else if (clr) wr_m = 1'b0;
    if (clr)      tout_m = 1'b0;
    tick();
    write_en = 1'b0; clear_err = 1'b0;
    check("idle_cfg", cfg_out, cfg_m);
    check("idle_wr_err", wr_err, wr_m);
    check("idle_tout_err", tout_err, tout_m);
    check("idle_busy", busy, 0);
  endtask

  task automatic clear_errs();
    clear_err = 1'b1;
    wr_m = 1'b0; tout_m = 1'b0;
    tick();
    clear_err = 1'b0;
    check("clr_wr_err", wr_err, 0);
    check("clr_tout_err", tout_err, 0);
  endtask

  // rdy: cycles cmd_valid stays high (ready on the last one)
  // dn : 0 = done with ready; 1..TO = done on that waiting cycle; <0 or >TO = never
  // bw : also attempt a write on the first waiting cycle
  task automatic do_cmd(input logic [CFG_W-1:0] cfg, input logic [CMD_W-1:0] cmd,
                        input int rdy, input int dn, input bit bw);
    exp_t e;
    int   nw;
    bit   tmo;
    tmo = (dn < 0) || (dn > TO);
    nw  = (dn == 0) ? 0 : (tmo ? TO : dn);
    if (nw == 0) bw = 1'b0;
    cfg_m = cfg;
    if (tmo) tout_m = 1'b1;
    if (bw)  wr_m = 1'b1;
    e.cfg = cfg; e.cmd = cmd; e.valid_cyc = rdy; e.wait_cyc = nw;
    e.tout = tout_m; e.wr = wr_m;
    q.push_back(e);
    exp_done++;
    write_en = 1'b1; wdata = {cmd, cfg};
    tick();
    write_en = 1'b0;
    for (int i = 1; i <= rdy; i++) begin
      if (i == rdy) begin cmd_ready = 1'b1; cmd_done = (dn == 0); end
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b0;
    end
    for (int j = 1; j <= nw; j++) begin
      if (j == dn) cmd_done = 1'b1;
      if (bw && j == 1) begin write_en = 1'b1; wdata = 12'($urandom); end
      tick();
      cmd_done = 1'b0; write_en = 1'b0;
    end
    tick();  // leave DONE
    check("busy_after_done", busy, 0);
    check("cfg_after_done", cfg_out, cfg_m);
    // stray controller handshakes in IDLE must be ignored
    cmd_ready = 1'($urandom); cmd_done = 1'($urandom);
    tick();
    cmd_ready = 1'b0; cmd_done = 1'b0;
    check("idle_stays", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CMD_W-1:0] bc;
    int               op, dn;
    #12;
    check("rst_cfg", cfg_out, 0);
    check("rst_cmd", cmd_out, 0);
    check("rst_flags", {cmd_valid, busy, done_pulse, wr_err, tout_err}, 0);
    n_rst = 1'b1;
    tick();

    // directed cases
    idle_write(8'hA5, 4'b0000, 1'b0);
    do_cmd(8'h3C, CMD_W'(1 << CMD_START), 3, 5, 1'b0);
    idle_write(8'hFF, 4'b0101, 1'b0);
    clear_errs();
    do_cmd(8'h11, CMD_W'(1 << CMD_TX), 1, 6, 1'b1);
    do_cmd(8'h22, CMD_W'(1 << CMD_STOP), 2, -1, 1'b0);
    clear_errs();
    do_cmd(8'h33, CMD_W'(1 << CMD_RX), 1, TO, 1'b0);
    do_cmd(8'h44, CMD_W'(1 << CMD_START), 2, 0, 1'b0);
    idle_write(8'h55, 4'b1100, 1'b1);  // clear and new error together: set wins

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: idle_write(8'($urandom), 4'b0000, 1'($urandom));
        1: begin
          do bc = 4'($urandom_range(1, 15)); while ($countones(bc) < 2);
          idle_write(8'($urandom), bc, 1'($urandom));
        end
        2: clear_errs();
        default: begin
          case ($urandom_range(0, 3))
            0:       dn = -1;
            1:       dn = 0;
            default: dn = $urandom_range(1, TO + 2);
          endcase
          do_cmd(8'($urandom), CMD_W'(1 << $urandom_range(0, 3)),
                 $urandom_range(1, 4), dn, 1'($urandom));
        end
      endcase
    end

    // reset in the middle of a command
    idle_write(8'hEE, 4'b0011, 1'b0);  // leave wr_err set
    begin
      exp_t e;
      e.cfg = 8'h77; e.cmd = CMD_W'(1 << CMD_TX); e.valid_cyc = 1; e.wait_cyc = 0;
      e.tout = 1'b0; e.wr = 1'b1;
      q.push_back(e);
    end
    write_en = 1'b1; wdata = {CMD_W'(1 << CMD_TX), 8'h77};
    tick();
    write_en = 1'b0; cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
    tick();
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_cfg", cfg_out, 0);
    check("mid_rst_cmd", cmd_out, 0);
    check("mid_rst_flags", {cmd_valid, busy, done_pulse, wr_err, tout_err}, 0);
    q.delete();
    cfg_m = '0; wr_m = 1'b0; tout_m = 1'b0;
    #3 n_rst = 1'b1;
    repeat (TO + 4) tick();
    check("post_rst_busy", busy, 0);

    check("done_count", popped, exp_done);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
